c_samq_pop_sched: RTL and testbench

//  Pop-side scheduler for a statically allocated multi-queue (SAMQ). Consumes per-queue empty flags

---
 rtl/c_samq_pop_sched.sv | 84 ++++++++
 tb/tb_c_samq_pop_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/c_samq_pop_sched.sv
// Pop-side round-robin scheduler for a statically allocated multi-queue.
// Grants at most one non-empty, credited queue per cycle and tracks downstream credits per queue.
module c_samq_pop_sched #(
    parameter int num_queues  = 4,
    parameter int num_credits = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_active,
    input  logic [num_queues-1:0] i_empty_qu,
    input  logic                  i_stall,
    input  logic [num_queues-1:0] i_credit_return_qu,
    output logic                  o_pop_valid,
    output logic [num_queues-1:0] o_pop_sel_qu,
    output logic [num_queues-1:0] o_credits_avail_qu,
    output logic [num_queues-1:0] o_errors_qu
);

    localparam int              CW         = $clog2(num_credits + 1);
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(num_credits);
    localparam logic [num_queues-1:0] ONE  = num_queues'(1);

    logic [CW-1:0]         r_credit [num_queues];
    logic [num_queues-1:0] r_prio_qu;

    logic [num_queues-1:0] w_elig;
    logic [num_queues-1:0] w_avail;
    logic [num_queues-1:0] w_full;
    logic [num_queues-1:0] w_mask;
    logic [num_queues-1:0] w_hi;
    logic [num_queues-1:0] w_pick_hi;
    logic [num_queues-1:0] w_pick_all;
    logic [num_queues-1:0] w_grant;
    logic [num_queues-1:0] w_inc;
    logic                  w_pop;

    always_comb begin
        for (int q = 0; q < num_queues; q++) begin
            w_avail[q] = (r_credit[q] != '0);
            w_full[q]  = (r_credit[q] == CREDIT_MAX);
        end
    end

    assign w_elig = ~i_empty_qu & w_avail;

    // Requests at or above the priority pointer win; otherwise wrap to the lowest requester.
    assign w_mask     = ~(r_prio_qu - ONE);
    assign w_hi       = w_elig & w_mask;
    assign w_pick_hi  = w_hi & (~w_hi + ONE);
    assign w_pick_all = w_elig & (~w_elig + ONE);

    assign w_pop   = i_active & ~i_stall & (|w_elig);
    assign w_grant = !w_pop ? '0 : ((|w_hi) ? w_pick_hi : w_pick_all);
    assign w_inc   = i_credit_return_qu;

    assign o_pop_valid        = w_pop;
    assign o_pop_sel_qu       = w_grant;
    assign o_credits_avail_qu = w_avail;
    assign o_errors_qu        = w_inc & ~w_grant & w_full;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prio_qu <= ONE;
        end else if (w_pop) begin
            r_prio_qu <= {w_grant[num_queues-2:0], w_grant[num_queues-1]};
        end
    end

    // Returns are accepted even while inactive so no credit is ever lost.
    always_ff @(posedge i_clk) begin
        for (int q = 0; q < num_queues; q++) begin
            if (i_reset) begin
                r_credit[q] <= CREDIT_MAX;
            end else if (i_active | w_inc[q]) begin
                if (w_grant[q] & ~w_inc[q]) begin
                    r_credit[q] <= r_credit[q] - CW'(1);
                end else if (w_inc[q] & ~w_grant[q] & ~w_full[q]) begin
                    r_credit[q] <= r_credit[q] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_c_samq_pop_sched.sv
// Directed bench for c_samq_pop_sched: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_c_samq_pop_sched;

    typedef struct {
        string      name;
        logic       valid;
        logic [3:0] sel;
        logic [3:0] avail;
        logic [3:0] err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       active;
    logic [3:0] empty;
    logic       stall;
    logic [3:0] ret;
    logic       popValid;
    logic [3:0] popSel;
    logic [3:0] creditsAvail;
    logic [3:0] errors;

    exp_t expQ[$];
    int   checks;
    int   failures;

    c_samq_pop_sched #(.num_queues(4), .num_credits(4)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_active           (active),
        .i_empty_qu         (empty),
        .i_stall            (stall),
        .i_credit_return_qu (ret),
        .o_pop_valid        (popValid),
        .o_pop_sel_qu       (popSel),
        .o_credits_avail_qu (creditsAvail),
        .o_errors_qu        (errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        checks += 4;
        if (popValid !== e.valid) begin
            failures++;
            $display("[TB] FAIL %s pop_valid got=%b want=%b", e.name, popValid, e.valid);
        end
        if (popSel !== e.sel) begin
            failures++;
            $display("[TB] FAIL %s pop_sel got=%b want=%b", e.name, popSel, e.sel);
        end
        if (creditsAvail !== e.avail) begin
            failures++;
            $display("[TB] FAIL %s credits_avail got=%b want=%b", e.name, creditsAvail, e.avail);
        end
        if (errors !== e.err) begin
            failures++;
            $display("[TB] FAIL %s errors got=%b want=%b", e.name, errors, e.err);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    task automatic applyStimulus(input string name, input logic act, input logic stl,
                                 input logic [3:0] emp, input logic [3:0] rt,
                                 input logic expV, input logic [3:0] expSel,
                                 input logic [3:0] expAvail, input logic [3:0] expErr);
        exp_t e;
        active = act;
        stall  = stl;
        empty  = emp;
        ret    = rt;
        e.name = name; e.valid = expV; e.sel = expSel; e.avail = expAvail; e.err = expErr;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        reset = 1'b1; active = 1'b1; stall = 1'b1; empty = 4'b1111; ret = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; active = 1'b1; stall = 1'b1; empty = 4'b1111; ret = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus("reset_state", 1, 1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b1111, 4'b0000);

        // Round robin across all queues, two full laps
        for (int k = 0; k < 8; k++) begin
            applyStimulus("rr_all", 1, 0, 4'b0000, 4'b0000, 1, 4'(1 << (k % 4)), 4'b1111, 4'b0000);
        end

        // Only q2 non-empty: four pops drain its credits
        resetPulse();
        for (int k = 0; k < 4; k++) begin
            applyStimulus("q2_drain", 1, 0, 4'b1011, 4'b0000, 1, 4'b0100, 4'b1111, 4'b0000);
        end
        applyStimulus("q2_no_credit", 1, 0, 4'b1011, 4'b0000, 0, 4'b0000, 4'b1011, 4'b0000);

        // Bring q1 to its last credit, then pop it with a simultaneous return
        for (int k = 0; k < 3; k++) begin
            applyStimulus("q1_to_one", 1, 0, 4'b1101, 4'b0000, 1, 4'b0010, 4'b1011, 4'b0000);
        end
        applyStimulus("q1_pop_ret", 1, 0, 4'b1101, 4'b0010, 1, 4'b0010, 4'b1011, 4'b0000);
        applyStimulus("q1_pop_again", 1, 0, 4'b1101, 4'b0000, 1, 4'b0010, 4'b1011, 4'b0000);
        applyStimulus("q1_exhausted", 1, 0, 4'b1101, 4'b0000, 0, 4'b0000, 4'b1001, 4'b0000);

        // Overflow return on full q0
        applyStimulus("q0_overflow", 1, 0, 4'b1111, 4'b0001, 0, 4'b0000, 4'b1001, 4'b0001);
        applyStimulus("q0_saturated", 1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 4'b1001, 4'b0000);

        // Refill q1/q2, then pop q2 so priority points at q3
        applyStimulus("refill", 1, 0, 4'b1111, 4'b0110, 0, 4'b0000, 4'b1001, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("refill", 1, 0, 4'b1111, 4'b0110, 0, 4'b0000, 4'b1111, 4'b0000);
        end
        applyStimulus("prio_to_q3", 1, 0, 4'b1011, 4'b0000, 1, 4'b0100, 4'b1111, 4'b0000);

        // Stall freezes grants and priority
        for (int k = 0; k < 3; k++) begin
            applyStimulus("stall", 1, 1, 4'b0110, 4'b0000, 0, 4'b0000, 4'b1111, 4'b0000);
        end
        applyStimulus("unstall_q3", 1, 0, 4'b0110, 4'b0000, 1, 4'b1000, 4'b1111, 4'b0000);
        applyStimulus("unstall_q0", 1, 0, 4'b0110, 4'b0000, 1, 4'b0001, 4'b1111, 4'b0000);

        // q2 to credit 2, return while inactive, then three pops prove credit 3
        applyStimulus("q2_to_two", 1, 0, 4'b1011, 4'b0000, 1, 4'b0100, 4'b1111, 4'b0000);
        applyStimulus("inactive_ret", 0, 0, 4'b1011, 4'b0100, 0, 4'b0000, 4'b1111, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("q2_three", 1, 0, 4'b1011, 4'b0000, 1, 4'b0100, 4'b1111, 4'b0000);
        end
        applyStimulus("q2_empty_cr", 1, 0, 4'b1011, 4'b0000, 0, 4'b0000, 4'b1011, 4'b0000);

        // Reset overrides a pending pop and return
        reset = 1'b1;
        applyStimulus("reset_pending", 1, 0, 4'b0000, 4'b0100, 1, 4'b1000, 4'b1011, 4'b0000);
        reset = 1'b0;
        applyStimulus("post_reset_q0", 1, 0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b1111, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            applyStimulus("post_reset_q2", 1, 0, 4'b1011, 4'b0000, 1, 4'b0100, 4'b1111, 4'b0000);
        end
        applyStimulus("post_reset_q2_out", 1, 0, 4'b1011, 4'b0000, 0, 4'b0000, 4'b1011, 4'b0000);

        stall = 1'b1;
        for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
            @(posedge clk);
        end
        if (expQ.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain pending got=%0d want=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
